seg_blink_driver: RTL and testbench

SEG_BLINK_DRIVER -- requirements
Module: seg_blink_driver

---
 rtl/seg_blink_driver.sv | 99 +++++++++
 tb/tb_seg_blink_driver.sv | 138 +++++++++++++
 2 files changed

// File: rtl/seg_blink_driver.sv
// Four-digit seven-segment pad driver with atomic pattern commit, per-digit
// blinking, lamp test and selectable pad polarity.
module seg_blink_driver #(
    parameter int CLK_HZ     = 50000000,
    parameter int BLINK_HZ   = 2,
    parameter bit ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] seg_hd,
    input  logic [6:0] seg_hu,
    input  logic [6:0] seg_md,
    input  logic [6:0] seg_mu,
    input  logic       commit,
    input  logic [3:0] blink_mask,
    input  logic       lamp_test,
    output logic [6:0] hex3,
    output logic [6:0] hex2,
    output logic [6:0] hex1,
    output logic [6:0] hex0,
    output logic       blink_phase
);

    localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);
    localparam logic [6:0] DARK = ACTIVE_LOW ? 7'h7F : 7'h00;

    generate
        if (HALF < 1) begin : g_bad_half
            $error("seg_blink_driver: CLK_HZ/(2*BLINK_HZ) must be at least 1");
        end
    endgenerate

    logic [6:0]    seg_in [4];
    logic [6:0]    shadow_q [4];
    logic [6:0]    hex_q [4];
    logic [6:0]    hex_d [4];
    logic [CW-1:0] cnt_q;
    logic [3:0]    mask_q;
    logic          phase_q;

    assign seg_in[3] = seg_hd;
    assign seg_in[2] = seg_hu;
    assign seg_in[1] = seg_md;
    assign seg_in[0] = seg_mu;

    // Visible value per digit, then folded to pad polarity before registering.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            logic [6:0] vis;
            always_comb begin
                vis = 7'h00;
                if (lamp_test)
                    vis = 7'h7F;
                else if (!blink_mask[gi] || phase_q)
                    vis = shadow_q[gi];
                hex_d[gi] = ACTIVE_LOW ? ~vis : vis;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= 7'h00;
                hex_q[i]    <= DARK;
            end
            cnt_q   <= '0;
            mask_q  <= 4'b0000;
            phase_q <= 1'b1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (commit)
                    shadow_q[i] <= seg_in[i];
                hex_q[i] <= hex_d[i];
            end
            // A mask edit restarts the blink so newly enabled digits begin lit.
            if (blink_mask != mask_q) begin
                mask_q  <= blink_mask;
                cnt_q   <= '0;
                phase_q <= 1'b1;
            end else if (cnt_q == LAST) begin
                cnt_q   <= '0;
                phase_q <= ~phase_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign hex3        = hex_q[3];
    assign hex2        = hex_q[2];
    assign hex1        = hex_q[1];
    assign hex0        = hex_q[0];
    assign blink_phase = phase_q;

endmodule

// File: tb/tb_seg_blink_driver.sv
// Directed bench for seg_blink_driver at CLK_HZ=8, BLINK_HZ=1 (HALF=4),
// ACTIVE_LOW=1; expected pad values are hand-computed inverses of patterns.
module tb_seg_blink_driver;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] seg_hd = 7'h00, seg_hu = 7'h00, seg_md = 7'h00, seg_mu = 7'h00;
    logic       commit = 1'b0;
    logic [3:0] blink_mask = 4'b0000;
    logic       lamp_test = 1'b0;
    logic [6:0] hex3, hex2, hex1, hex0;
    logic       blink_phase;

    int checks = 0;
    int failures = 0;

    seg_blink_driver #(.CLK_HZ(8), .BLINK_HZ(1), .ACTIVE_LOW(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .seg_hd(seg_hd), .seg_hu(seg_hu), .seg_md(seg_md), .seg_mu(seg_mu),
        .commit(commit), .blink_mask(blink_mask), .lamp_test(lamp_test),
        .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
        .blink_phase(blink_phase)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                             input logic [6:0] e1, input logic [6:0] e0);
        check({tag, ".hex3"}, hex3, e3);
        check({tag, ".hex2"}, hex2, e2);
        check({tag, ".hex1"}, hex1, e1);
        check({tag, ".hex0"}, hex0, e0);
    endtask

    initial begin
        // Reset held across a couple of edges
        step(2);
        check_all("reset", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        check("reset.phase", {6'b0, blink_phase}, 7'h01);

        // Release away from the edge; first wrap is four edges later
        reset_n = 1'b1;
        step(3);
        check_all("idle", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        check("idle.phase_e3", {6'b0, blink_phase}, 7'h01);
        step(1);
        check("idle.phase_e4", {6'b0, blink_phase}, 7'h00);

        // Commit hd=06: shadow at edge t, pad after t+1
        seg_hd = 7'h06;
        commit = 1'b1;
        step(1);
        commit = 1'b0;
        check("commit.latency", hex3, 7'h7F);
        step(1);
        check("commit.hex3", hex3, 7'h79);
        seg_hd = 7'h5B;
        step(2);
        check("nocommit.hex3", hex3, 7'h79);

        // Commit all digits together with a mask change (edge A)
        seg_hd = 7'h06; seg_hu = 7'h66; seg_md = 7'h6D; seg_mu = 7'h3F;
        blink_mask = 4'b0001;
        commit = 1'b1;
        step(1);
        commit = 1'b0;
        check("maskA.phase", {6'b0, blink_phase}, 7'h01);
        step(1);
        check_all("A+1", 7'h79, 7'h19, 7'h12, 7'h40);
        step(3);
        check("A+4.phase", {6'b0, blink_phase}, 7'h00);
        check("A+4.hex0", hex0, 7'h40);
        step(1);
        check_all("A+5", 7'h79, 7'h19, 7'h12, 7'h7F);
        step(3);
        check("A+8.phase", {6'b0, blink_phase}, 7'h01);
        check("A+8.hex0", hex0, 7'h7F);
        step(1);
        check("A+9.hex0", hex0, 7'h40);

        // Mid dark phase (A+13), widen mask; restart at edge B
        step(4);
        check("A+13.hex0", hex0, 7'h7F);
        blink_mask = 4'b0011;
        step(1);
        check("B.phase", {6'b0, blink_phase}, 7'h01);
        check("B.hex0", hex0, 7'h7F);
        step(1);
        check_all("B+1", 7'h79, 7'h19, 7'h12, 7'h40);
        step(2);
        check("B+3.phase", {6'b0, blink_phase}, 7'h01);
        step(1);
        check("B+4.phase", {6'b0, blink_phase}, 7'h00);
        step(1);
        check("B+5.hex0", hex0, 7'h7F);

        // Lamp test in the dark phase, then resume
        lamp_test = 1'b1;
        step(1);
        check_all("lamp", 7'h00, 7'h00, 7'h00, 7'h00);
        lamp_test = 1'b0;
        step(1);
        check_all("B+7", 7'h79, 7'h19, 7'h7F, 7'h7F);
        step(1);
        check("B+8.phase", {6'b0, blink_phase}, 7'h01);
        step(1);
        check_all("B+9", 7'h79, 7'h19, 7'h12, 7'h40);

        // Asynchronous reset between edges
        #2;
        reset_n = 1'b0;
        #1;
        check_all("async_rst", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        check("async_rst.phase", {6'b0, blink_phase}, 7'h01);
        step(1);
        reset_n = 1'b1;
        step(2);
        check_all("post_rst", 7'h7F, 7'h7F, 7'h7F, 7'h7F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
